fp_div: RTL and testbench

- Sequential IEEE-754 single-precision divider, R = A / B.
- It is the inverse companion to the FPU multiply path. It shares that path's start/done operand interface, so the top level can mux it in as a fourth operation.
- Uses restoring mantissa division, one quotient bit per clock, then normalize and round-to-nearest-even with guard/round/sticky bits.
- Fixed latency regardless of operand values.

---
 rtl/fp_div_if.sv | 17 +
 rtl/fp_div.sv | 179 +++++++++++++++++
 tb/tb_fp_div.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_div_if.sv
// Operand/result bundle for the sequential single-precision divider.
// Shares the start/done shape of the multiply path so a top level can mux it in.
// Master drives operands and start; slave returns the result, status and flags.
interface fp_div_if;
    logic [31:0] A;
    logic [31:0] B;
    logic        start;
    logic [31:0] R;
    logic        done;
    logic        busy;
    logic        dbz;
    logic        ovf;
    logic        unf;

    modport master (output A, B, start, input R, done, busy, dbz, ovf, unf);
    modport slave  (input A, B, start, output R, done, busy, dbz, ovf, unf);
endinterface

// File: rtl/fp_div.sv
// IEEE-754 single-precision divider R = A / B: restoring division, one quotient bit per clock, RNE rounding.
// Latency: done rises exactly 30 clk edges after the edge that accepts start, independent of operands.
// No backpressure: start is only taken in IDLE/DONE and ignored while busy; done is level-held until the next start.
module fp_div #(
    parameter int QBITS = 27,
    parameter int BIAS  = 127
) (
    input  logic    clk,
    input  logic    rst,
    fp_div_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_UNPACK, S_DIVIDE, S_NORM, S_ROUND, S_DONE
    } state_t;

    state_t             state_q;
    logic [31:0]        a_q, b_q, r_q;
    logic               done_q, busy_q, dbz_q, ovf_q, unf_q;
    logic               sign_q;
    logic [23:0]        mb_q;
    logic [24:0]        rem_q;
    logic [QBITS-1:0]   q_q;
    logic signed [9:0]  e_q;
    logic [4:0]         cnt_q;
    logic               spec_q, spec_dbz_q;
    logic [31:0]        spec_r_q;

    // Unpack: operand classification and the biased exponent difference
    logic               sign_d, spec_d, spec_dbz_d;
    logic [31:0]        spec_r_d;
    logic signed [9:0]  e_d;
    logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    always_comb begin
        a_zero     = (a_q[30:23] == 8'h00);
        b_zero     = (b_q[30:23] == 8'h00);
        a_inf      = (&a_q[30:23]) && (a_q[22:0] == 23'h0);
        b_inf      = (&b_q[30:23]) && (b_q[22:0] == 23'h0);
        a_nan      = (&a_q[30:23]) && (a_q[22:0] != 23'h0);
        b_nan      = (&b_q[30:23]) && (b_q[22:0] != 23'h0);
        sign_d     = a_q[31] ^ b_q[31];
        e_d        = {2'b00, a_q[30:23]} - {2'b00, b_q[30:23]} + 10'(BIAS);
        spec_d     = 1'b1;
        spec_dbz_d = 1'b0;
        spec_r_d   = 32'h7FC0_0000;
        if (a_nan || b_nan) begin
            spec_r_d = 32'h7FC0_0000;
        end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_dbz_d = 1'b1;
        end else if (b_zero) begin
            // A is finite and nonzero here
            spec_r_d   = {sign_d, 8'hFF, 23'h0};
            spec_dbz_d = 1'b1;
        end else if (a_inf) begin
            spec_r_d = {sign_d, 8'hFF, 23'h0};
        end else if (a_zero || b_inf) begin
            spec_r_d = {sign_d, 31'h0};
        end else begin
            spec_d = 1'b0;
        end
    end

    // Divide step: trial subtract, then shift remainder and quotient
    logic        ge;
    logic [23:0] rem_sub;

    always_comb begin
        ge      = (rem_q >= {1'b0, mb_q});
        // after a successful subtract the remainder is below mB, so 24 bits hold it
        rem_sub = ge ? 24'(rem_q - {1'b0, mb_q}) : rem_q[23:0];
    end

    // Round: increment {exponent, fraction} together so a mantissa carry bumps the exponent
    logic              inc;
    logic [32:0]       rnd_sum;
    logic signed [9:0] e_r;
    logic [22:0]       frac_r;

    always_comb begin
        inc     = q_q[2] & (q_q[1] | q_q[0] | (|rem_q) | q_q[3]);
        rnd_sum = {e_q, q_q[QBITS-2 -: 23]} + 33'(inc);
        e_r     = $signed(rnd_sum[32:23]);
        frac_r  = rnd_sum[22:0];
    end

    // Control FSM with all datapath state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            r_q        <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            dbz_q      <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            sign_q     <= 1'b0;
            mb_q       <= '0;
            rem_q      <= '0;
            q_q        <= '0;
            e_q        <= '0;
            cnt_q      <= '0;
            spec_q     <= 1'b0;
            spec_dbz_q <= 1'b0;
            spec_r_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        a_q     <= bus.A;
                        b_q     <= bus.B;
                        done_q  <= 1'b0;
                        dbz_q   <= 1'b0;
                        ovf_q   <= 1'b0;
                        unf_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    sign_q     <= sign_d;
                    mb_q       <= {1'b1, b_q[22:0]};
                    rem_q      <= {2'b01, a_q[22:0]};
                    q_q        <= '0;
                    e_q        <= e_d;
                    cnt_q      <= '0;
                    spec_q     <= spec_d;
                    spec_dbz_q <= spec_dbz_d;
                    spec_r_q   <= spec_r_d;
                    state_q    <= S_DIVIDE;
                end
                S_DIVIDE: begin
                    rem_q <= {rem_sub, 1'b0};
                    q_q   <= {q_q[QBITS-2:0], ge};
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'(QBITS - 1)) begin
                        state_q <= S_NORM;
                    end
                end
                S_NORM: begin
                    // quotient of two [1,2) mantissas is in (0.5,2): at most one left shift
                    if (!q_q[QBITS-1]) begin
                        q_q <= q_q << 1;
                        e_q <= e_q - 10'sd1;
                    end
                    state_q <= S_ROUND;
                end
                S_ROUND: begin
                    if (spec_q) begin
                        r_q   <= spec_r_q;
                        dbz_q <= spec_dbz_q;
                    end else if (e_r >= 10'sd255) begin
                        r_q   <= {sign_q, 8'hFF, 23'h0};
                        ovf_q <= 1'b1;
                    end else if (e_r <= 10'sd0) begin
                        r_q   <= {sign_q, 31'h0};
                        unf_q <= 1'b1;
                    end else begin
                        r_q <= {sign_q, e_r[7:0], frac_r};
                    end
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.R    = r_q;
    assign bus.done = done_q;
    assign bus.busy = busy_q;
    assign bus.dbz  = dbz_q;
    assign bus.ovf  = ovf_q;
    assign bus.unf  = unf_q;

endmodule

// File: tb/tb_fp_div.sv
// Scoreboarded bench for fp_div: directed cases with fixed expected words, then random operands
// checked against an integer long-division reference model. A monitor pops expectations on
// every rising edge of done and checks result, flags and 30-cycle latency.
module tb_fp_div;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;

    fp_div_if bus();

    fp_div dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] r;
        logic        dbz;
        logic        ovf;
        logic        unf;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    logic done_prev;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: exact integer quotient with 40 fraction bits, then RNE to 24 bits
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t        m;
        logic        s, az, bz, ai, bi, an, bn, half, rest;
        logic [63:0] num, den, quo;
        logic        remnz;
        logic [24:0] mant;
        int          e;
        m.r = 32'h0; m.dbz = 1'b0; m.ovf = 1'b0; m.unf = 1'b0; m.acc = 0;
        s  = a[31] ^ b[31];
        az = (a[30:23] == 8'h00);
        bz = (b[30:23] == 8'h00);
        ai = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
        bi = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
        an = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
        bn = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
        if (an || bn) begin
            m.r = 32'h7FC00000;
        end else if ((az && bz) || (ai && bi)) begin
            m.r = 32'h7FC00000; m.dbz = 1'b1;
        end else if (bz) begin
            m.r = {s, 8'hFF, 23'h0}; m.dbz = 1'b1;
        end else if (ai) begin
            m.r = {s, 8'hFF, 23'h0};
        end else if (az || bi) begin
            m.r = {s, 31'h0};
        end else begin
            num   = {40'h0, 1'b1, a[22:0]} << 40;
            den   = {40'h0, 1'b1, b[22:0]};
            quo   = num / den;
            remnz = (num % den) != 64'h0;
            e     = int'(a[30:23]) - int'(b[30:23]) + 127;
            if (quo[40]) begin
                mant = {1'b0, quo[40:17]};
                half = quo[16];
                rest = (quo[15:0] != 16'h0) || remnz;
            end else begin
                e    = e - 1;
                mant = {1'b0, quo[39:16]};
                half = quo[15];
                rest = (quo[14:0] != 15'h0) || remnz;
            end
            if (half && (rest || mant[0])) mant = mant + 25'd1;
            if (mant[24]) begin
                mant = 25'h0800000;
                e    = e + 1;
            end
            if (e >= 255) begin
                m.r = {s, 8'hFF, 23'h0}; m.ovf = 1'b1;
            end else if (e <= 0) begin
                m.r = {s, 31'h0}; m.unf = 1'b1;
            end else begin
                m.r = {s, 8'(e), mant[22:0]};
            end
        end
        return m;
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [7:0]  e;
        logic [22:0] f;
        case ($urandom_range(0, 9))
            0:       e = 8'h00;
            1:       e = 8'hFF;
            2:       e = 8'($urandom_range(1, 254));
            default: e = 8'($urandom_range(100, 154));
        endcase
        f = ($urandom_range(0, 3) == 0) ? 23'h0 : 23'($urandom);
        return {1'($urandom), e, f};
    endfunction

    // Monitor: every rising edge of done must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.done && !done_prev) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", 32'(bus.done), 32'h0);
            end else begin
                e = exp_q.pop_front();
                check("R",       bus.R,           e.r);
                check("dbz",     32'(bus.dbz),    32'(e.dbz));
                check("ovf",     32'(bus.ovf),    32'(e.ovf));
                check("unf",     32'(bus.unf),    32'(e.unf));
                check("latency", 32'(cyc - e.acc), 32'd30);
                check("busy_at_done", 32'(bus.busy), 32'h0);
            end
        end
        done_prev = bus.done;
    end

    // Called at a negedge: start is sampled on the following posedge
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input exp_t e);
        exp_t t;
        t     = e;
        t.acc = cyc + 1;
        bus.A = a;
        bus.B = b;
        bus.start = 1'b1;
        exp_q.push_back(t);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic issue_k(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] r, input logic dbz, input logic ovf, input logic unf);
        exp_t e;
        e.r = r; e.dbz = dbz; e.ovf = ovf; e.unf = unf; e.acc = 0;
        issue(a, b, e);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL wait_done: timed out with %0d results outstanding", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        logic [31:0] ra, rb;
        cyc       = 0;
        checks    = 0;
        errors    = 0;
        done_prev = 1'b0;
        rst       = 1'b1;
        bus.A     = 32'h0;
        bus.B     = 32'h0;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_R",    bus.R,            32'h0);
        check("rst_done", 32'(bus.done),    32'h0);
        check("rst_busy", 32'(bus.busy),    32'h0);
        check("rst_flags", 32'({bus.dbz, bus.ovf, bus.unf}), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Basic quotient 6/2 with busy visible after acceptance
        issue_k(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 1'b0);
        check("busy_after_start", 32'(bus.busy), 32'h1);
        check("done_after_start", 32'(bus.done), 32'h0);
        wait_idle();

        // 1/3 exercises the normalize shift and a round-up; start at +10 must be ignored
        issue_k(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 1'b0, 1'b0);
        check("start_from_done_clears", 32'(bus.done), 32'h0);
        repeat (9) @(negedge clk);
        bus.A = 32'h40C00000;
        bus.B = 32'h40000000;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();

        // Signs, specials, overflow and underflow
        issue_k(32'hBF800000, 32'h40800000, 32'hBE800000, 1'b0, 1'b0, 1'b0); wait_idle();
        issue_k(32'hBF800000, 32'hC0800000, 32'h3E800000, 1'b0, 1'b0, 1'b0); wait_idle();
        issue_k(32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 1'b0, 1'b0); wait_idle();
        issue_k(32'h00000000, 32'h00000000, 32'h7FC00000, 1'b1, 1'b0, 1'b0); wait_idle();
        issue_k(32'h7F000000, 32'h00800000, 32'h7F800000, 1'b0, 1'b1, 1'b0); wait_idle();
        issue_k(32'h00800000, 32'h7F000000, 32'h00000000, 1'b0, 1'b0, 1'b1); wait_idle();

        // Reset at cycle 15 of an operation aborts it
        issue_k(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 1'b0);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(exp_q.pop_back());
        check("abort_R",    bus.R,         32'h0);
        check("abort_done", 32'(bus.done), 32'h0);
        check("abort_busy", 32'(bus.busy), 32'h0);
        check("abort_flags", 32'({bus.dbz, bus.ovf, bus.unf}), 32'h0);
        repeat (40) @(negedge clk);
        check("abort_no_done", 32'(bus.done), 32'h0);
        issue_k(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 1'b0);
        wait_idle();

        // Random operands against the reference model, back to back from DONE
        for (int i = 0; i < 150; i++) begin
            ra = rand_fp();
            rb = rand_fp();
            issue(ra, rb, model(ra, rb));
            wait_idle();
        end

        repeat (3) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
